// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder: operands and start in, status and result out.
// The ovf member exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor using one full-adder cell, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             cmsb_q, cmsb_d;
    logic             ovf_q, ovf_d;
`endif

    logic fa_sum_c;
    logic fa_carry_c;

    // The single full-adder cell shared by every bit position
    assign fa_sum_c   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_carry_c = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        cmsb_d  = cmsb_q;
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // Subtract is a + ~b + 1, so cin is replaced by the +1
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                sum_d   = {fa_sum_c, sum_q[WIDTH-1:1]};
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = fa_carry_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB position
                    cmsb_d  = carry_q;
`endif
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                cout_d  = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
                ovf_d   = cmsb_q ^ carry_q;
`endif
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            cmsb_q  <= cmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): expected results queued at issue, compared at done.
module tb_serial_adder;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned W1    = WIDTH + 1;
    localparam int          DONE_BOUND = 40;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + W1'(sub ? 1'b1 : cin);
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Called at a negedge; start is sampled on the following posedge
    task automatic issue_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
        sb_q.push_back(model(a, b, cin, sub));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        bus.cin   = 1'($urandom);
        bus.sub   = 1'($urandom);
    endtask

    task automatic wait_done(output bit ok, output int cycles, output int busy_cycles);
        ok          = 1'b0;
        cycles      = 0;
        busy_cycles = bus.busy ? 1 : 0;
        while (cycles < DONE_BOUND) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++;
        if (bus.sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", bus.sum); end
        checks++;
        if (bus.cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] ta[3] = '{8'h00, 8'hFF, 8'h3C};
        logic [WIDTH-1:0] tb[3] = '{8'h00, 8'h01, 8'hA5};
        logic             tc[3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            bit ok; int cyc; int bcyc; exp_t e;
            issue_op(ta[i], tb[i], tc[i], 1'b0);
            wait_done(ok, cyc, bcyc);
            checks++;
            if (!ok || sb_q.size() == 0) begin
                failures++; $display("FAIL add_done[%0d] no done within %0d cycles", i, DONE_BOUND);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (bus.sum !== e.sum) begin failures++; $display("FAIL add_sum[%0d] got=%h exp=%h", i, bus.sum, e.sum); end
                checks++;
                if (bus.cout !== e.cout) begin failures++; $display("FAIL add_cout[%0d] got=%b exp=%b", i, bus.cout, e.cout); end
`ifdef SERIAL_ADDER_OVF_EN
                checks++;
                if (bus.ovf !== e.ovf) begin failures++; $display("FAIL add_ovf[%0d] got=%b exp=%b", i, bus.ovf, e.ovf); end
`endif
                if (i == 0) begin
                    checks++;
                    if (cyc != WIDTH + 1) begin failures++; $display("FAIL add_latency got=%0d exp=%0d", cyc, WIDTH + 1); end
                    checks++;
                    if (bcyc != WIDTH) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=%0d", bcyc, WIDTH); end
                end
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0) begin failures++; $display("FAIL add_done_pulse[%0d] got=%b exp=0", i, bus.done); end
        end
    endtask

    task automatic test_sub();
        logic [WIDTH-1:0] ta[3] = '{8'h05, 8'h07, 8'h5A};
        logic [WIDTH-1:0] tb[3] = '{8'h07, 8'h05, 8'h00};
        logic             tc[3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            bit ok; int cyc; int bcyc; exp_t e;
            issue_op(ta[i], tb[i], tc[i], 1'b1);
            wait_done(ok, cyc, bcyc);
            checks++;
            if (!ok || sb_q.size() == 0) begin
                failures++; $display("FAIL sub_done[%0d] no done within %0d cycles", i, DONE_BOUND);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (bus.sum !== e.sum) begin failures++; $display("FAIL sub_sum[%0d] got=%h exp=%h", i, bus.sum, e.sum); end
                checks++;
                if (bus.cout !== e.cout) begin failures++; $display("FAIL sub_cout[%0d] got=%b exp=%b", i, bus.cout, e.cout); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        bit ok; int cyc; int bcyc; exp_t e; bit seen;
        issue_op(8'h3C, 8'hA5, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.sub = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(ok, cyc, bcyc);
        checks++;
        if (!ok || sb_q.size() == 0) begin
            failures++; $display("FAIL ignore_done no done within %0d cycles", DONE_BOUND);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (bus.sum !== e.sum) begin failures++; $display("FAIL ignore_sum got=%h exp=%h", bus.sum, e.sum); end
            checks++;
            if (bus.cout !== e.cout) begin failures++; $display("FAIL ignore_cout got=%b exp=%b", bus.cout, e.cout); end
        end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL ignore_queued got=activity exp=idle"); end
        issue_op(8'h11, 8'h22, 1'b0, 1'b0);
        wait_done(ok, cyc, bcyc);
        checks++;
        if (!ok || sb_q.size() == 0) begin
            failures++; $display("FAIL ignore_second_done no done within %0d cycles", DONE_BOUND);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (bus.sum !== e.sum) begin failures++; $display("FAIL ignore_second_sum got=%h exp=%h", bus.sum, e.sum); end
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bit ok; int cyc; int bcyc; exp_t e; bit seen;
        issue_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(ok, cyc, bcyc);
        checks++;
        if (!ok || sb_q.size() == 0) begin
            failures++; $display("FAIL rst_pre_done no done within %0d cycles", DONE_BOUND);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (bus.cout !== e.cout) begin failures++; $display("FAIL rst_pre_cout got=%b exp=%b", bus.cout, e.cout); end
        end
        @(negedge clk);
        issue_op(8'hC3, 8'h5A, 1'b1, 1'b0);
        void'(sb_q.pop_back());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", bus.done); end
        checks++;
        if (bus.sum !== 8'h00) begin failures++; $display("FAIL rst_mid_sum got=%h exp=00", bus.sum); end
        checks++;
        if (bus.cout !== 1'b0) begin failures++; $display("FAIL rst_mid_cout got=%b exp=0", bus.cout); end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL rst_mid_no_done got=done exp=none"); end
        issue_op(8'h12, 8'h34, 1'b1, 1'b0);
        wait_done(ok, cyc, bcyc);
        checks++;
        if (!ok || sb_q.size() == 0) begin
            failures++; $display("FAIL rst_fresh_done no done within %0d cycles", DONE_BOUND);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (bus.sum !== e.sum) begin failures++; $display("FAIL rst_fresh_sum got=%h exp=%h", bus.sum, e.sum); end
            checks++;
            if (cyc != WIDTH + 1) begin failures++; $display("FAIL rst_fresh_latency got=%0d exp=%0d", cyc, WIDTH + 1); end
        end
        @(negedge clk);
    endtask

    // Each new start is driven in the done cycle, the earliest legal slot
    task automatic test_back_to_back();
        bit ok; int cyc; int bcyc; exp_t e;
        issue_op(8'h80, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            wait_done(ok, cyc, bcyc);
            checks++;
            if (!ok || sb_q.size() == 0) begin
                failures++; $display("FAIL b2b_done[%0d] no done within %0d cycles", i, DONE_BOUND);
                break;
            end
            e = sb_q.pop_front();
            checks++;
            if (bus.sum !== e.sum || bus.cout !== e.cout) begin
                failures++;
                $display("FAIL b2b_result[%0d] got=%h/%b exp=%h/%b", i, bus.sum, bus.cout, e.sum, e.cout);
            end
`ifdef SERIAL_ADDER_OVF_EN
            checks++;
            if (bus.ovf !== e.ovf) begin failures++; $display("FAIL b2b_ovf[%0d] got=%b exp=%b", i, bus.ovf, e.ovf); end
`endif
            if (i > 0) begin
                checks++;
                if (cyc != WIDTH + 1) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, cyc, WIDTH + 1); end
            end
            if (i < 9) issue_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [WIDTH-1:0] ta[3] = '{8'h7F, 8'h80, 8'h10};
        logic [WIDTH-1:0] tb[3] = '{8'h01, 8'hFF, 8'h20};
        logic             ov[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            bit ok; int cyc; int bcyc; exp_t e;
            issue_op(ta[i], tb[i], 1'b0, 1'b0);
            wait_done(ok, cyc, bcyc);
            checks++;
            if (!ok || sb_q.size() == 0) begin
                failures++; $display("FAIL ovf_done[%0d] no done within %0d cycles", i, DONE_BOUND);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (bus.ovf !== ov[i]) begin failures++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, bus.ovf, ov[i]); end
                checks++;
                if (bus.sum !== e.sum || bus.cout !== e.cout) begin
                    failures++;
                    $display("FAIL ovf_result[%0d] got=%h/%b exp=%h/%b", i, bus.sum, bus.cout, e.sum, e.cout);
                end
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
